// File: rtl/fft_pkg.sv
// Shared types and size constants for the FFT stage sequencer.
package fft_pkg;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } fsm_state_t;

  // Default transform size and the constants derived from it
  localparam int DEF_LOG2_N = 4;
  localparam int N          = 1 << DEF_LOG2_N;
  localparam int HALF_N     = N / 2;
  localparam int STG_W      = $clog2(DEF_LOG2_N);

  // Gap counter width covers the full 0..15 gap range
  localparam int GAP_W = 4;

  // Butterflies per stage for a given log2 size
  function automatic int half_n_of(input int log2n);
    return (1 << log2n) / 2;
  endfunction

endpackage

// File: rtl/flex_counter.sv
// Generic up-counter with synchronous clear, enable and a registered
// rollover flag that is high while the count equals rollover_val.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] r_count;
  logic                    r_flag;
  logic [NUM_CNT_BITS-1:0] w_count_next;

  // Next count: clear wins, otherwise step and wrap to zero after rollover_val
  always_comb begin
    w_count_next = r_count;
    if (clear) begin
      w_count_next = '0;
    end else if (count_enable) begin
      if (r_count == rollover_val) begin
        w_count_next = '0;
      end else begin
        w_count_next = r_count + 1'b1;
      end
    end
  end

  // Count and flag registers; the flag tracks the value being loaded
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
      r_flag  <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_flag  <= (w_count_next == rollover_val);
    end
  end

  assign count_out     = r_count;
  assign rollover_flag = r_flag;

endmodule

// File: rtl/fft_stage_sequencer.sv
// In-place radix-2 DIT FFT stage sequencer: walks LOG2_N stages of N/2
// butterflies, emitting operand addresses and twiddle index for each, with
// an idle gap between stages so datapath write-backs settle.
module fft_stage_sequencer #(
  parameter int LOG2_N     = 4,
  parameter int GAP_CYCLES = 3,
  parameter int STG_W      = $clog2(LOG2_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              bf_ready,
  output logic              busy,
  output logic              bf_valid,
  output logic [LOG2_N-1:0] addr_a,
  output logic [LOG2_N-1:0] addr_b,
  output logic [LOG2_N-2:0] tw_idx,
  output logic [STG_W-1:0]  stage,
  output logic              last_bf,
  output logic              done
);
  import fft_pkg::*;

  localparam int                BF_PER_STG = half_n_of(LOG2_N);
  localparam logic [LOG2_N-1:0] J_LAST     = LOG2_N'(BF_PER_STG - 1);
  localparam logic [STG_W-1:0]  S_LAST     = STG_W'(LOG2_N - 1);
  localparam logic [GAP_W-1:0]  G_LAST     = GAP_W'(GAP_CYCLES - 1);

  fsm_state_t        r_state;
  logic [STG_W-1:0]  r_stage;
  logic [GAP_W-1:0]  r_gap_cnt;

  logic [LOG2_N-1:0] w_j;
  logic              w_j_last;
  logic              w_transfer;
  logic              w_stage_end;
  logic              w_start_go;
  logic              w_j_clear;
  logic              w_cnt_n_rst;

  logic [LOG2_N-1:0] w_one_s;
  logic [LOG2_N-1:0] w_pos;
  logic [LOG2_N-1:0] w_grp;
  logic [LOG2_N-1:0] w_base_a;
  logic [STG_W-1:0]  w_tw_shift;
  logic [LOG2_N-2:0] w_tw;

  assign bf_valid    = (r_state == RUN);
  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);
  assign stage       = r_stage;
  assign w_transfer  = bf_valid & bf_ready;
  assign w_stage_end = w_transfer & w_j_last;
  assign w_start_go  = (r_state == IDLE) & start & ~abort;

  // The butterfly counter restarts on a new transform, on cancel, at the end
  // of every stage, and while reset is held so reset behaves synchronously.
  assign w_j_clear   = rst | abort | w_start_go | w_stage_end;
  assign w_cnt_n_rst = ~rst;

  flex_counter #(
    .NUM_CNT_BITS (LOG2_N)
  ) u_j_cnt (
    .clk           (clk),
    .n_rst         (w_cnt_n_rst),
    .clear         (w_j_clear),
    .count_enable  (w_transfer),
    .rollover_val  (J_LAST),
    .count_out     (w_j),
    .rollover_flag (w_j_last)
  );

  // Sequencer FSM with stage register and inter-stage gap counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_stage   <= '0;
      r_gap_cnt <= '0;
    end else if (abort) begin
      r_state   <= IDLE;
      r_stage   <= '0;
      r_gap_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state   <= RUN;
            r_stage   <= '0;
            r_gap_cnt <= '0;
          end
        end
        RUN: begin
          if (w_stage_end) begin
            if (r_stage == S_LAST) begin
              r_state <= DONE;
            end else begin
              r_stage   <= r_stage + 1'b1;
              r_gap_cnt <= '0;
              r_state   <= (GAP_CYCLES == 0) ? RUN : GAP;
            end
          end
        end
        GAP: begin
          if (r_gap_cnt == G_LAST) begin
            r_gap_cnt <= '0;
            r_state   <= RUN;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_stage <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Butterfly address and twiddle generation from the registered j and s
  always_comb begin
    w_one_s    = LOG2_N'(1) << r_stage;
    w_pos      = w_j & (w_one_s - 1'b1);
    w_grp      = w_j >> r_stage;
    w_base_a   = ((w_grp << r_stage) << 1) | w_pos;
    w_tw_shift = S_LAST - r_stage;
    // pos < 2^s <= 2^(LOG2_N-1), so dropping its top bit loses nothing
    w_tw       = (LOG2_N-1)'(w_pos) << w_tw_shift;
  end

  assign addr_a  = bf_valid ? w_base_a : '0;
  assign addr_b  = bf_valid ? (w_base_a | w_one_s) : '0;
  assign tw_idx  = bf_valid ? w_tw : '0;
  assign last_bf = bf_valid & (r_stage == S_LAST) & (w_j == J_LAST);

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer: a 16-point/gap-3 instance and a
// 4-point/gap-0 instance, with hand-computed expected timing and addresses.
module tb_fft_stage_sequencer;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // 16-point, gap 3
  logic       rst, start, abort, bf_ready;
  logic       busy, bf_valid, last_bf, done;
  logic [3:0] addr_a, addr_b;
  logic [2:0] tw_idx;
  logic [1:0] stage;

  // 4-point, gap 0
  logic       start2, abort2, ready2;
  logic       busy2, valid2, last2, done2;
  logic [1:0] a2, b2;
  logic [0:0] tw2;
  logic [0:0] stage2;

  int n_checks = 0;
  int n_fail   = 0;

  fft_stage_sequencer #(.LOG2_N(4), .GAP_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .bf_ready(bf_ready),
    .busy(busy), .bf_valid(bf_valid), .addr_a(addr_a), .addr_b(addr_b),
    .tw_idx(tw_idx), .stage(stage), .last_bf(last_bf), .done(done)
  );

  fft_stage_sequencer #(.LOG2_N(2), .GAP_CYCLES(0)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2), .bf_ready(ready2),
    .busy(busy2), .bf_valid(valid2), .addr_a(a2), .addr_b(b2),
    .tw_idx(tw2), .stage(stage2), .last_bf(last2), .done(done2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Valid windows of the 16-point, gap-3 schedule with start at edge 0
  function automatic bit in_run4(input int c);
    return (c >= 1 && c <= 8) || (c >= 12 && c <= 19) ||
           (c >= 23 && c <= 30) || (c >= 34 && c <= 41);
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; bf_ready = 1'b1;
    start2 = 1'b0; abort2 = 1'b0; ready2 = 1'b1;
    repeat (3) tick();

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_valid", bf_valid, 0);
    chk("rst_addr_a", addr_a, 0);
    chk("rst_addr_b", addr_b, 0);
    chk("rst_tw", tw_idx, 0);
    chk("rst_stage", stage, 0);
    chk("rst_last", last_bf, 0);
    chk("rst_done", done, 0);
    chk("rst_busy2", busy2, 0);
    chk("rst_valid2", valid2, 0);
    rst = 1'b0;
    tick();

    // Full transform, bf_ready held high
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 43; c++) begin
      if (bf_valid && bf_ready)
        $display("xfer run1 cyc=%0d s=%0d a=%0d b=%0d tw=%0d last=%0d", c, stage, addr_a, addr_b, tw_idx, last_bf);
      chk($sformatf("run1_valid_c%0d", c), bf_valid, in_run4(c));
      chk($sformatf("run1_done_c%0d", c), done, (c == 42));
      chk($sformatf("run1_busy_c%0d", c), busy, (c <= 42));
      if (c == 4) begin
        chk("s0j3_addr_a", addr_a, 6);
        chk("s0j3_addr_b", addr_b, 7);
        chk("s0j3_tw", tw_idx, 0);
        chk("s0j3_stage", stage, 0);
      end
      if (c == 9) begin
        chk("gap_stage", stage, 1);
        chk("gap_addr_a", addr_a, 0);
        chk("gap_addr_b", addr_b, 0);
      end
      if (c == 17) begin
        chk("s1j5_addr_a", addr_a, 9);
        chk("s1j5_addr_b", addr_b, 11);
        chk("s1j5_tw", tw_idx, 4);
        chk("s1j5_stage", stage, 1);
      end
      if (c == 40) chk("s3j6_last", last_bf, 0);
      if (c == 41) begin
        chk("s3j7_addr_a", addr_a, 7);
        chk("s3j7_addr_b", addr_b, 15);
        chk("s3j7_tw", tw_idx, 7);
        chk("s3j7_stage", stage, 3);
        chk("s3j7_last", last_bf, 1);
      end
      tick();
    end

    // Stall four cycles at stage 2, j=2
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 47; c++) begin
      bf_ready = (c >= 25 && c <= 28) ? 1'b0 : 1'b1;
      if (c >= 25 && c <= 29) begin
        chk($sformatf("stall_valid_c%0d", c), bf_valid, 1);
        chk($sformatf("stall_addr_a_c%0d", c), addr_a, 2);
        chk($sformatf("stall_addr_b_c%0d", c), addr_b, 6);
        chk($sformatf("stall_tw_c%0d", c), tw_idx, 4);
        chk($sformatf("stall_stage_c%0d", c), stage, 2);
      end
      if (c >= 40) begin
        chk($sformatf("stall_done_c%0d", c), done, (c == 46));
        chk($sformatf("stall_busy_c%0d", c), busy, (c <= 46));
      end
      tick();
    end
    bf_ready = 1'b1;

    // Abort in the gap after stage 1
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 26; c++) begin
      abort = (c == 21);
      if (c == 20) begin
        chk("abort_pre_busy", busy, 1);
        chk("abort_pre_valid", bf_valid, 0);
        chk("abort_pre_stage", stage, 2);
      end
      if (c == 21) chk("abort_cyc_busy", busy, 1);
      if (c >= 22) begin
        chk($sformatf("abort_busy_c%0d", c), busy, 0);
        chk($sformatf("abort_done_c%0d", c), done, 0);
        chk($sformatf("abort_valid_c%0d", c), bf_valid, 0);
      end
      tick();
    end
    abort = 1'b0;

    // Restart after abort, with start pulses while busy that must be ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_stage", stage, 0);
    chk("restart_addr_a", addr_a, 0);
    chk("restart_addr_b", addr_b, 1);
    for (int c = 1; c <= 44; c++) begin
      start = ((c >= 3 && c <= 10) || c == 20) ? 1'b1 : 1'b0;
      if (c == 2) begin
        chk("restart_j1_addr_a", addr_a, 2);
        chk("restart_j1_addr_b", addr_b, 3);
      end
      chk($sformatf("busy_start_valid_c%0d", c), bf_valid, in_run4(c));
      chk($sformatf("busy_start_done_c%0d", c), done, (c == 42));
      chk($sformatf("busy_start_busy_c%0d", c), busy, (c <= 42));
      tick();
    end

    // start together with abort in IDLE is ignored
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    chk("start_abort_valid", bf_valid, 0);
    tick();
    chk("start_abort_busy_late", busy, 0);

    // 4-point instance with no inter-stage gap
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (valid2)
        $display("xfer n4 cyc=%0d s=%0d a=%0d b=%0d tw=%0d last=%0d", c, stage2, a2, b2, tw2, last2);
      chk($sformatf("n4_valid_c%0d", c), valid2, (c <= 4));
      chk($sformatf("n4_done_c%0d", c), done2, (c == 5));
      chk($sformatf("n4_busy_c%0d", c), busy2, (c <= 5));
      case (c)
        1: begin chk("n4_c1_a", a2, 0); chk("n4_c1_b", b2, 1); chk("n4_c1_tw", tw2, 0); chk("n4_c1_s", stage2, 0); end
        2: begin chk("n4_c2_a", a2, 2); chk("n4_c2_b", b2, 3); chk("n4_c2_tw", tw2, 0); end
        3: begin chk("n4_c3_a", a2, 0); chk("n4_c3_b", b2, 2); chk("n4_c3_s", stage2, 1); chk("n4_c3_last", last2, 0); end
        4: begin chk("n4_c4_a", a2, 1); chk("n4_c4_b", b2, 3); chk("n4_c4_tw", tw2, 1); chk("n4_c4_last", last2, 1); end
        default: ;
      endcase
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
